data_ram_ctrl: RTL and testbench
================================

# data_ram_ctrl

Parametrised single-clock data RAM for the core's load/store path. It has independent write and read ports, each with a valid/ready handshake. Writes use per-byte strobes. Reads have a fixed one-cycle registered latency. After every reset a hardware init sweep zero-fills the array. Out-of-range accesses are flagged, and read-during-write forwarding can be compiled in or out.

## Interface
- DATA_W, 32: word width in bits; multiple of 8, at least 8.
- DEPTH, 256: number of words; at least 2, need not be a power of two.
- ADDR_W, 32: byte-address width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once the zero-fill sweep has completed.
- wr_valid  in  1  write request.
- wr_ready  out  1  write port can accept; equals init_done.
- wr_addr  in  ADDR_W  byte address of the write.
- wr_data  in  DATA_W  write data.
- wr_strb  in  DATA_W/8  byte-lane write enables; bit i covers wr_data[8i+7:8i].
- wr_err  out  1  one-cycle pulse, cycle after an out-of-range write is accepted.
- rd_valid  in  1  read request.
- rd_ready  out  1  read port can accept; equals init_done.
- rd_addr  in  ADDR_W  byte address of the read.
- rd_data  out  DATA_W  registered read data.
- rd_data_valid  out  1  one-cycle pulse qualifying rd_data and rd_err.
- rd_err  out  1  out-of-range flag for the returned read.

## Operation
- Word index calculation:
  - idx = addr >> log2(DATA_W/8); the low byte-offset bits are ignored.
  - An access is in range iff idx < DEPTH.
- The FSM has two states, INIT and RUN.
- INIT state:
  - Entered on any cycle with rst high.
  - A counter walks idx 0..DEPTH-1 and writes zero to one word per cycle.
  - On the cycle it writes DEPTH-1, the FSM moves to RUN.
  - The ready outputs are low throughout; requests presented are ignored and produce no response.
- RUN state:
  - init_done, wr_ready and rd_ready are all 1.
- Write acceptance:
  - A write is accepted when wr_valid && wr_ready.
  - If in range, each byte lane whose wr_strb bit is 1 is updated; other lanes keep their value. wr_strb = 0 writes nothing and raises no error.
  - If out of range, the memory is untouched and wr_err pulses the next cycle.
- Read acceptance:
  - A read is accepted when rd_valid && rd_ready.
  - The next cycle, rd_data_valid = 1.
  - If in range: rd_data = the word contents and rd_err = 0.
  - If out of range: rd_data = 0 and rd_err = 1.
- rd_data holds its value until the next accepted read. rd_err is meaningful only while rd_data_valid = 1.
- The write and read ports run fully concurrently; back-to-back accepts are allowed every cycle on both ports.
- Same-cycle write and read of the same in-range word: behaviour is set by RAM_FWD_EN (see Configuration).

## Timing
- Reset values (also held while rst = 1):
  - init_done = 0, wr_ready = 0, rd_ready = 0.
  - rd_data = 0, rd_data_valid = 0, rd_err = 0, wr_err = 0.
  - The init counter is 0.
- Init sequence:
  - The first zero-write happens on the first edge with rst low.
  - init_done rises exactly DEPTH cycles after rst deasserts.
- Reset asserted mid-operation or mid-init:
  - Any read response pending for the next cycle is dropped.
  - The counter restarts at 0 and the full sweep repeats.
- Read latency is 1 cycle, from the accept edge to rd_data_valid.
- Write-to-read ordering: a write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- wr_err latency is 1 cycle after the accept.

## Configuration
- Macro: RAM_FWD_EN.
- Defined: a same-cycle in-range read and write to the same idx returns the merged word.
  - Lanes with wr_strb set take wr_data.
  - All other lanes take the old contents.
- Undefined: the same case returns the old contents (read-before-write). The write still completes normally.
- The macro has no effect on out-of-range accesses or on INIT.

## Test plan
- Reset and init (DEPTH=256): deassert rst, then hold valids high.
  - Required: ready = 0 for exactly 256 cycles, then 1.
  - Required: a subsequent read of addr 0x3FC returns 0x00000000 with rd_err = 0.
- Byte strobes:
  - Write 0x11223344 to 0x10 with strb 4'b1111.
  - Then write 0xAABBCCDD to 0x10 with strb 4'b0101.
  - Read 0x10, one cycle later. Required: rd_data = 0x11BB33DD.
- Out of range:
  - Write to 0x400 (idx 256). Required: wr_err pulses one cycle later and memory is unchanged.
  - Read 0x400. Required: rd_data = 0, rd_err = 1, rd_data_valid = 1.
- Collision:
  - Word 0x20 holds 0xCAFEF00D. In the same cycle, write 0x12345678 with strb 4'b0011 and read 0x20.
  - Required with RAM_FWD_EN: 0xCAFE5678. Required without it: 0xCAFEF00D.
  - A following read returns 0xCAFE5678 in both builds.
- Streaming: 8 back-to-back reads at 0x0..0x1C after writing the values 1..8.
  - Required: rd_data_valid is high for 8 consecutive cycles, returning 1..8 in order.
- Mid-operation reset: assert rst for 1 cycle in the cycle after a read is accepted.
  - Required: no rd_data_valid pulse, the ready outputs drop, and init_done returns DEPTH cycles after rst deasserts.
  - Required: all words read back as 0.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - byte-strobed data RAM with zero-fill init sweep and optional RAM_FWD_EN read-during-write forwarding
module data_ram_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  wr_err,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic [ADDR_W-1:0] wr_word;
    logic [ADDR_W-1:0] rd_word;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word_data;

    logic              rd_vld_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_err_q;

    // Outputs read as their reset values while rst is high, even before the first edge.
    assign run       = (state == S_RUN) && !rst;
    assign init_done = run;
    assign wr_ready  = run;
    assign rd_ready  = run;

    assign wr_word     = wr_addr >> OFF_W;
    assign rd_word     = rd_addr >> OFF_W;
    assign wr_idx      = wr_word[IDX_W-1:0];
    assign rd_idx      = rd_word[IDX_W-1:0];
    assign wr_in_range = wr_word < DEPTH_A;
    assign rd_in_range = rd_word < DEPTH_A;
    assign wr_acc      = wr_valid && run;
    assign rd_acc      = rd_valid && run;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Leave INIT on the cycle the last word is zeroed.
    always_comb begin
        state_next = state;
        case (state)
            S_INIT:  if (init_cnt == LAST_IDX) state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_INIT;
        endcase
    end

    // Sweep counter: one word per cycle while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Array write: zero-fill during INIT, strobed lane updates in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                mem[init_cnt] <= '0;
            end else if (wr_acc && wr_in_range) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Word seen by the read port, optionally merged with a same-cycle write.
    always_comb begin
        rd_word_data = mem[rd_idx];
`ifdef RAM_FWD_EN
        if (wr_acc && wr_in_range && rd_in_range && (wr_idx == rd_idx)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_strb[b]) rd_word_data[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
`endif
    end

    // Registered read response; rd_data holds until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= rd_acc;
            if (rd_acc) begin
                rd_err_q  <= !rd_in_range;
                rd_data_q <= rd_in_range ? rd_word_data : '0;
            end
        end
    end

    // Out-of-range write flag, one cycle after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_acc && !wr_in_range;
        end
    end

    assign rd_data_valid = rd_vld_q && !rst;
    assign rd_err        = rd_err_q && !rst;
    assign rd_data       = rst ? '0 : rd_data_q;
    assign wr_err        = wr_err_q && !rst;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - scoreboard bench for data_ram_ctrl
module tb_data_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_err;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        time         t;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    logic    wr_q[$];

    data_ram_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done     (init_done),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_err        (wr_err),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_err        (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // Monitor: compares every read response and every write's error flag against the scoreboard.
    always @(negedge clk) begin
        rd_exp_t e;
        logic    we;
        if (rd_data_valid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected got data=%h err=%b required no response", rd_data, rd_err);
            end else begin
                e = rd_q.pop_front();
                if (rd_data !== e.data || rd_err !== e.err || ($time - e.t) != 5) begin
                    failures++;
                    $display("FAIL rd_resp got data=%h err=%b lat=%0t required data=%h err=%b lat=5",
                             rd_data, rd_err, $time - e.t, e.data, e.err);
                end
            end
        end
        if (wr_q.size() > 0) begin
            we = wr_q.pop_front();
            checks++;
            if (wr_err !== we) begin
                failures++;
                $display("FAIL wr_err got=%b required=%b", wr_err, we);
            end
        end else if (wr_err !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL wr_err_unexpected got=%b required=0", wr_err);
        end
    end

    // One cycle of traffic on both ports; expectations are queued at the accept edge.
    task automatic acc(input logic wv, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic rv, input logic [31:0] ra,
                       input logic [31:0] exp_d, input logic exp_e, input logic exp_we);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        wr_strb  = ws;
        rd_valid = rv;
        rd_addr  = ra;
        @(posedge clk);
        if (rv) rd_q.push_back('{data: exp_d, err: exp_e, t: $time});
        if (wv) wr_q.push_back(exp_we);
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic e);
        acc(1'b1, a, d, s, 1'b0, 32'h0, 32'h0, 1'b0, e);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
        acc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, d, e, 1'b0);
    endtask

    // Counts cycles with ready low after rst deassertion; called just after rst drops.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (rd_ready === 1'b1 && wr_ready === 1'b1 && init_done === 1'b1) break;
            n++;
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        check(name, n, 256);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
        check("rst_rd_ready", {31'h0, rd_ready}, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_flags", {29'h0, rd_data_valid, rd_err, wr_err}, 32'h0);

        // Release reset with requests held high: they must be ignored during the sweep.
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 32'h8;
        wr_data  = 32'hFFFF_FFFF;
        wr_strb  = 4'h0;
        rd_valid = 1'b1;
        rd_addr  = 32'h8;
        wait_init("init_cycles");
        rd(32'h3FC, 32'h0, 1'b0);

        // Byte strobes, offset bits ignored, empty strobe.
        wr(32'h10, 32'h1122_3344, 4'b1111, 1'b0);
        wr(32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0);
        rd(32'h10, 32'h11BB_33DD, 1'b0);
        wr(32'h10, 32'h0000_0000, 4'b0000, 1'b0);
        rd(32'h13, 32'h11BB_33DD, 1'b0);

        // Out of range: index 256 must not alias word 0.
        wr(32'h400, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        rd(32'h0, 32'h0, 1'b0);
        rd(32'h400, 32'h0, 1'b1);
        rd(32'h3FC, 32'h0, 1'b0);

        // Same-cycle collision.
        wr(32'h20, 32'hCAFE_F00D, 4'b1111, 1'b0);
`ifdef RAM_FWD_EN
        acc(1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b1, 32'h20, 32'hCAFE_5678, 1'b0, 1'b0);
`else
        acc(1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0);
`endif
        rd(32'h20, 32'hCAFE_5678, 1'b0);

        // Streaming writes then back-to-back reads.
        for (int i = 0; i < 8; i++) wr(32'(i * 4), 32'(i + 1), 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) rd(32'(i * 4), 32'(i + 1), 1'b0);

        // Mid-operation reset: read accepted, then rst for one cycle; no response expected.
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 32'h4;
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_ready", {30'h0, rd_ready, wr_ready}, 32'h0);
        check("midrst_init_done", {31'h0, init_done}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init("reinit_cycles");
        for (int i = 0; i < 256; i++) rd(32'(i * 4), 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rd_q_drained", rd_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
